// File: rtl/wash_cycle_ctrl.sv
// Washing-machine programme sequencer.
// Runs FILL -> (WASH -> RINSE) x N -> SPIN -> optional DRY, or a STEAM-only
// programme. Every phase lasts a fixed number of time ticks. A prescaler
// derives the tick from clk. Pause freezes all timing. Abort diverts any
// running phase into DRAIN.
module wash_cycle_ctrl #(
   parameter int CNT_W    = 8,
   parameter int TICK_DIV = 1,
   parameter int T_FILL   = 10,
   parameter int T_WASH   = 50,
   parameter int T_RINSE  = 50,
   parameter int T_SPIN   = 20,
   parameter int T_DRY    = 60,
   parameter int T_STEAM  = 60,
   parameter int T_DRAIN  = 15,
   parameter int MAX_WASH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       wash_count,
   input  logic             dry_en,
   input  logic             steam_mode,
   input  logic             pause,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] remaining,
   output logic [1:0]       wash_idx,
   output logic             paused
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      RINSE = 3'd3,
      SPIN  = 3'd4,
      DRY   = 3'd5,
      STEAM = 3'd6,
      DRAIN = 3'd7
   } state_t;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] DIV_M1 = PW'(TICK_DIV - 1);

   localparam logic [CNT_W-1:0] R_FILL  = CNT_W'(T_FILL - 1);
   localparam logic [CNT_W-1:0] R_WASH  = CNT_W'(T_WASH - 1);
   localparam logic [CNT_W-1:0] R_RINSE = CNT_W'(T_RINSE - 1);
   localparam logic [CNT_W-1:0] R_SPIN  = CNT_W'(T_SPIN - 1);
   localparam logic [CNT_W-1:0] R_DRY   = CNT_W'(T_DRY - 1);
   localparam logic [CNT_W-1:0] R_STEAM = CNT_W'(T_STEAM - 1);
   localparam logic [CNT_W-1:0] R_DRAIN = CNT_W'(T_DRAIN - 1);
   localparam logic [1:0]       MAX_M   = 2'(MAX_WASH);

   state_t          state;
   logic [PW-1:0]   presc;
   logic [1:0]      cfg_washes;
   logic            cfg_dry;
   logic            tick;

   // Requested pass count forced into 1..MAX_WASH (0 means a single pass).
   function automatic logic [1:0] clamp_washes(input logic [1:0] wc);
      logic [1:0] r;
      r = wc;
      if (wc == 2'd0)
         r = 2'd1;
      else if (wc > MAX_M)
         r = MAX_M;
      return r;
   endfunction

   // The tick fires when the prescaler reaches its last count and pause is low.
   assign tick = !pause && (presc == DIV_M1);

   // Status outputs follow directly from the state register.
   assign busy   = (state != IDLE);
   assign paused = pause && busy;
   assign phase  = state;

   // This block holds the programme sequencer, the phase countdown, the prescaler and the completion pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         remaining  <= '0;
         presc      <= '0;
         wash_idx   <= 2'd0;
         cfg_washes <= 2'd0;
         cfg_dry    <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         case (state)
            IDLE: begin
               presc     <= '0;
               remaining <= '0;
               wash_idx  <= 2'd0;
               if (start) begin
                  cfg_washes <= clamp_washes(wash_count);
                  cfg_dry    <= dry_en;
                  // A steam programme is carried by the STEAM state itself,
                  // so the mode needs no separate register.
                  if (steam_mode) begin
                     state     <= STEAM;
                     remaining <= R_STEAM;
                  end else begin
                     state     <= FILL;
                     remaining <= R_FILL;
                  end
               end
            end

            DRAIN: begin
               if (!pause) begin
                  if (tick) begin
                     presc <= '0;
                     if (remaining != '0) begin
                        remaining <= remaining - 1'b1;
                     end else begin
                        state     <= IDLE;
                        aborted   <= 1'b1;
                        remaining <= '0;
                        wash_idx  <= 2'd0;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
            end

            FILL, WASH, RINSE, SPIN, DRY, STEAM: begin
               if (abort) begin
                  state     <= DRAIN;
                  remaining <= R_DRAIN;
                  presc     <= '0;
               end else if (!pause) begin
                  if (tick) begin
                     presc <= '0;
                     if (remaining != '0) begin
                        remaining <= remaining - 1'b1;
                     end else begin
                        case (state)
                           FILL: begin
                              state     <= WASH;
                              remaining <= R_WASH;
                           end
                           WASH: begin
                              state     <= RINSE;
                              remaining <= R_RINSE;
                              wash_idx  <= wash_idx + 2'd1;
                           end
                           RINSE: begin
                              if (wash_idx < cfg_washes) begin
                                 state     <= WASH;
                                 remaining <= R_WASH;
                              end else begin
                                 state     <= SPIN;
                                 remaining <= R_SPIN;
                              end
                           end
                           SPIN: begin
                              if (cfg_dry) begin
                                 state     <= DRY;
                                 remaining <= R_DRY;
                              end else begin
                                 state     <= IDLE;
                                 done      <= 1'b1;
                                 remaining <= '0;
                                 wash_idx  <= 2'd0;
                              end
                           end
                           default: begin
                              state     <= IDLE;
                              done      <= 1'b1;
                              remaining <= '0;
                              wash_idx  <= 2'd0;
                           end
                        endcase
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               remaining <= '0;
               presc     <= '0;
               wash_idx  <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed testbench for wash_cycle_ctrl. It uses a default-parameter
// instance plus a TICK_DIV=4 instance for the prescaler run.
module tb_wash_cycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start4 = 1'b0;
   logic [1:0] wash_count = 2'd0;
   logic       dry_en = 1'b0;
   logic       steam_mode = 1'b0;
   logic       pause = 1'b0;
   logic       abort = 1'b0;

   logic       busy, done, aborted, paused;
   logic [2:0] phase;
   logic [7:0] remaining;
   logic [1:0] wash_idx;

   logic       busy4, done4, aborted4, paused4;
   logic [2:0] phase4;
   logic [7:0] remaining4;
   logic [1:0] wash_idx4;

   int          checks = 0;
   int          errors = 0;
   int          busy_cycles;
   logic [31:0] seq_code;
   logic [2:0]  last_phase;
   logic [1:0]  max_idx;
   logic        end_done, end_aborted;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   wash_cycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .wash_count(wash_count),
      .dry_en(dry_en), .steam_mode(steam_mode), .pause(pause), .abort(abort),
      .busy(busy), .done(done), .aborted(aborted), .phase(phase),
      .remaining(remaining), .wash_idx(wash_idx), .paused(paused)
   );

   wash_cycle_ctrl #(.TICK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .wash_count(wash_count),
      .dry_en(dry_en), .steam_mode(steam_mode), .pause(pause), .abort(abort),
      .busy(busy4), .done(done4), .aborted(aborted4), .phase(phase4),
      .remaining(remaining4), .wash_idx(wash_idx4), .paused(paused4)
   );

   task automatic launch(input logic [1:0] wc, input logic de, input logic sm);
      @(negedge clk);
      wash_count = wc; dry_en = de; steam_mode = sm; start = 1'b1;
      @(negedge clk);
      start = 1'b0; wash_count = 2'd0; dry_en = 1'b0; steam_mode = 1'b0;
   endtask

   task automatic clear_stats();
      busy_cycles = 0; seq_code = 32'd0; last_phase = 3'd0; max_idx = 2'd0;
      end_done = 1'b0; end_aborted = 1'b0;
   endtask

   task automatic sample();
      if (busy) begin
         if (phase != last_phase) begin
            seq_code   = (seq_code << 3) | {29'd0, phase};
            last_phase = phase;
         end
         if (wash_idx > max_idx) max_idx = wash_idx;
         busy_cycles++;
      end
      @(negedge clk);
   endtask

   task automatic watch(input int limit);
      while (busy && busy_cycles < limit) sample();
      end_done    = done;
      end_aborted = aborted;
   endtask

   task automatic wait_for(input logic [2:0] p, input logic [7:0] r, input int limit, output logic found);
      while (busy && !(phase == p && remaining == r) && busy_cycles < limit) sample();
      found = busy && (phase == p) && (remaining == r);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pause = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, aborted, phase, remaining, wash_idx, paused} !== 17'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h want 0", {busy, done, aborted, phase, remaining, wash_idx, paused});
      end
      checks++;
      if ({busy4, done4, aborted4, phase4, remaining4, wash_idx4, paused4} !== 17'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs_div4: got %h want 0", {busy4, done4, aborted4, phase4, remaining4, wash_idx4, paused4});
      end
      pause = 1'b0; rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_pass();
      launch(2'd1, 1'b0, 1'b0);
      clear_stats();
      watch(400);
      checks++;
      if (busy_cycles !== 130) begin errors++; $display("[TB] FAIL single_len: got %0d want 130", busy_cycles); end
      checks++;
      if (seq_code !== 32'o1234) begin errors++; $display("[TB] FAIL single_seq: got %o want 1234", seq_code); end
      checks++;
      if ({end_done, end_aborted} !== 2'b10) begin errors++; $display("[TB] FAIL single_pulse: got %b want 10", {end_done, end_aborted}); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_width: got %b want 0", done); end
   endtask

   task automatic test_two_pass_dry();
      launch(2'd2, 1'b1, 1'b0);
      clear_stats();
      watch(20);
      start = 1'b1; steam_mode = 1'b1; wash_count = 2'd3;
      sample();
      start = 1'b0; steam_mode = 1'b0; wash_count = 2'd0;
      watch(600);
      checks++;
      if (busy_cycles !== 290) begin errors++; $display("[TB] FAIL two_pass_len: got %0d want 290", busy_cycles); end
      checks++;
      if (seq_code !== 32'o1232345) begin errors++; $display("[TB] FAIL two_pass_seq: got %o want 1232345", seq_code); end
      checks++;
      if (max_idx !== 2'd2) begin errors++; $display("[TB] FAIL two_pass_idx: got %0d want 2", max_idx); end
      checks++;
      if ({end_done, end_aborted} !== 2'b10) begin errors++; $display("[TB] FAIL two_pass_pulse: got %b want 10", {end_done, end_aborted}); end
   endtask

   task automatic test_steam();
      launch(2'd3, 1'b1, 1'b1);
      clear_stats();
      watch(200);
      checks++;
      if (busy_cycles !== 60) begin errors++; $display("[TB] FAIL steam_len: got %0d want 60", busy_cycles); end
      checks++;
      if (seq_code !== 32'o6) begin errors++; $display("[TB] FAIL steam_seq: got %o want 6", seq_code); end
      checks++;
      if (end_done !== 1'b1) begin errors++; $display("[TB] FAIL steam_done: got %b want 1", end_done); end
   endtask

   task automatic test_pause();
      logic found;
      launch(2'd1, 1'b0, 1'b0);
      clear_stats();
      wait_for(3'd2, 8'd30, 300, found);
      checks++;
      if (found !== 1'b1) begin errors++; $display("[TB] FAIL pause_reach: got %b want 1", found); end
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample();
         checks++;
         if ({phase, remaining, paused} !== {3'd2, 8'd30, 1'b1}) begin
            errors++;
            $display("[TB] FAIL pause_hold: got ph %0d rem %0d paused %b want ph 2 rem 30 paused 1", phase, remaining, paused);
         end
      end
      pause = 1'b0;
      sample();
      checks++;
      if (remaining !== 8'd29) begin errors++; $display("[TB] FAIL pause_resume: got %0d want 29", remaining); end
      watch(400);
      checks++;
      if (busy_cycles !== 135) begin errors++; $display("[TB] FAIL pause_len: got %0d want 135", busy_cycles); end
      checks++;
      if (end_done !== 1'b1) begin errors++; $display("[TB] FAIL pause_done: got %b want 1", end_done); end
   endtask

   task automatic test_tick_div();
      int cyc;
      @(negedge clk);
      wash_count = 2'd1; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; wash_count = 2'd0;
      cyc = 0;
      while (busy4 && cyc < 1000) begin
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (cyc !== 520) begin errors++; $display("[TB] FAIL div4_len: got %0d want 520", cyc); end
      checks++;
      if (done4 !== 1'b1) begin errors++; $display("[TB] FAIL div4_done: got %b want 1", done4); end
   endtask

   task automatic test_abort_wash();
      logic found;
      launch(2'd1, 1'b0, 1'b0);
      clear_stats();
      wait_for(3'd2, 8'd20, 300, found);
      checks++;
      if (found !== 1'b1) begin errors++; $display("[TB] FAIL abort_reach: got %b want 1", found); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({phase, remaining} !== {3'd7, 8'd14}) begin
         errors++;
         $display("[TB] FAIL abort_drain_entry: got ph %0d rem %0d want ph 7 rem 14", phase, remaining);
      end
      clear_stats();
      watch(100);
      checks++;
      if (busy_cycles !== 15) begin errors++; $display("[TB] FAIL drain_len: got %0d want 15", busy_cycles); end
      checks++;
      if ({end_done, end_aborted} !== 2'b01) begin errors++; $display("[TB] FAIL abort_pulse: got %b want 01", {end_done, end_aborted}); end
      @(negedge clk);
      checks++;
      if (aborted !== 1'b0) begin errors++; $display("[TB] FAIL aborted_width: got %b want 0", aborted); end
   endtask

   task automatic test_abort_rinse_end();
      logic found;
      launch(2'd2, 1'b0, 1'b0);
      clear_stats();
      wait_for(3'd3, 8'd0, 300, found);
      checks++;
      if (found !== 1'b1) begin errors++; $display("[TB] FAIL rinse_end_reach: got %b want 1", found); end
      abort = 1'b1; pause = 1'b1;
      @(negedge clk);
      abort = 1'b0; pause = 1'b0;
      checks++;
      if ({phase, remaining, wash_idx} !== {3'd7, 8'd14, 2'd1}) begin
         errors++;
         $display("[TB] FAIL rinse_abort: got ph %0d rem %0d idx %0d want ph 7 rem 14 idx 1", phase, remaining, wash_idx);
      end
      clear_stats();
      watch(100);
      checks++;
      if ({end_done, end_aborted} !== 2'b01) begin errors++; $display("[TB] FAIL rinse_abort_pulse: got %b want 01", {end_done, end_aborted}); end
   endtask

   task automatic test_reset_mid_spin();
      logic found;
      launch(2'd1, 1'b0, 1'b0);
      clear_stats();
      wait_for(3'd4, 8'd10, 300, found);
      checks++;
      if (found !== 1'b1) begin errors++; $display("[TB] FAIL spin_reach: got %b want 1", found); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, aborted, phase, remaining, wash_idx, paused} !== 17'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset: got %h want 0", {busy, done, aborted, phase, remaining, wash_idx, paused});
      end
      @(negedge clk);
      rst_n = 1'b1;
      launch(2'd0, 1'b0, 1'b0);
      clear_stats();
      watch(400);
      checks++;
      if (busy_cycles !== 130) begin errors++; $display("[TB] FAIL zero_count_len: got %0d want 130", busy_cycles); end
      checks++;
      if (seq_code !== 32'o1234) begin errors++; $display("[TB] FAIL zero_count_seq: got %o want 1234", seq_code); end
      checks++;
      if (max_idx !== 2'd1) begin errors++; $display("[TB] FAIL zero_count_idx: got %0d want 1", max_idx); end
      checks++;
      if (end_done !== 1'b1) begin errors++; $display("[TB] FAIL zero_count_done: got %b want 1", end_done); end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      test_reset();
      test_single_pass();
      test_two_pass_dry();
      test_steam();
      test_pause();
      test_tick_div();
      test_abort_wash();
      test_abort_rinse_end();
      test_reset_mid_spin();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound so a stuck design cannot hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
